mem_bank: RTL and testbench
===========================

// Module: mem_bank
// PURPOSE
//  Parametrised single-port synchronous memory bank, successor of the 8x8 memory_unit.
//  - Same select/op/addr access style; generalised word width and depth.
//  - Adds a registered read with data_valid, and a bulk-clear sweep engine with busy.
//  - Sits between the datapath controller and any block needing scratch storage.
// PARAMETERS
//  DATA_WIDTH  8  width of one stored word, in bits
//  ADDR_WIDTH  3  address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  clk         in   1           single clock; all state changes on the rising edge
//  rst_n       in   1           synchronous, active-low reset
//  select      in   1           access request; sampled only when busy=0
//  op          in   1           1 = write, 0 = read
//  addr        in   ADDR_WIDTH  word address
//  data_in     in   DATA_WIDTH  write data
//  clr         in   1           request a bulk clear of all words to 0
//  data_out    out  DATA_WIDTH  registered read data
//  data_valid  out  1           one-cycle pulse: data_out updated by a read
//  busy        out  1           clear sweep in progress; accesses are ignored
//  parity_err  out  1           read parity mismatch, aligned with data_valid (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states:
//    - CLEAR: sweep counter clr_ptr (ADDR_WIDTH+1 bits) writes 0 to mem[clr_ptr], one word per cycle.
//    - IDLE: services accesses.
//  - Reset (rst_n=0 at an edge):
//    - data_out=0, data_valid=0, parity_err=0.
//    - clr_ptr=0, state=CLEAR, busy=1.
//    - Memory is not reset directly; the sweep zeroes it.
//  - CLEAR: busy=1 for exactly DEPTH cycles after the reset/clr edge, then state=IDLE, busy=0.
//    - Cycle k (k = 0..DEPTH-1) writes word k.
//  - IDLE, clr=1: enter CLEAR with clr_ptr=0 on the next edge.
//    - clr has priority over a simultaneous select; that access is dropped.
//  - IDLE, select=1, op=1: mem[addr] <= data_in at the edge.
//    - data_valid stays 0; data_out holds its value.
//  - IDLE, select=1, op=0: data_out <= mem[addr] at the edge.
//    - data_valid=1 for that one cycle (latency 1).
//    - Back-to-back reads give back-to-back valid pulses.
//  - select=0, or busy=1: no memory change, data_valid=0, data_out holds.
//  - clr while busy=1 is ignored; the sweep is not restarted.
//  - Reset mid-sweep restarts the sweep at word 0 with a full DEPTH-cycle busy.
//  - Read of an address written in the previous cycle returns the new data (no hazard).
//  - Address is always in range (DEPTH = 2**ADDR_WIDTH); clr_ptr termination is at count == DEPTH.
// CONFIGURATION
//  - MEM_PARITY_EN defined:
//    - Each word stores an extra even-parity bit of data_in (sweep stores parity 0).
//    - On a read, parity_err <= (^stored_data != stored_parity), valid only with data_valid.
//    - parity_err is 0 in all other cycles.
//  - MEM_PARITY_EN undefined:
//    - No parity storage.
//    - parity_err is tied to 0; the port is always present.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=3)
//  - Reset: rst_n low 2 cycles, then release -> busy=1 for 8 cycles, then 0; data_out=0x00, data_valid=0.
//  - Write/read: write 0x49 @1, then read @1 -> next cycle data_out=0x49 with a single data_valid pulse.
//  - Corners: write 0xCC @0 and 0x33 @7, read @0 then @7 back-to-back -> 0xCC then 0x33, valid on 2 consecutive cycles.
//  - Clear: clr=1 together with a write of 0xFF @2 -> busy 8 cycles, access dropped; then read @1 and @2 -> 0x00.
//  - Busy lockout: read @0 and write 0xAA @3 while busy=1 -> no data_valid; after busy, read @3 -> 0x00.
//  - Parity (MEM_PARITY_EN): write 0x01 @4, bench flips the stored parity bit, read @4 -> data_out=0x01, parity_err=1 with data_valid.

Source files
------------

// File: rtl/mem_bank.sv
// mem_bank: parametrised single-port synchronous memory bank.
// Registered reads with a one-cycle data_valid pulse, plus a bulk-clear
// sweep engine that zeroes every word (one per cycle) after reset or clr.
// Optional feature: define MEM_PARITY_EN to store and check an even-parity
// bit per word; without it parity_err is tied low.
module mem_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  select,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SWEEP_END = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH:0]   clr_ptr_r;
    logic [ADDR_WIDTH:0]   clr_ptr_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  rd_en_s;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_PARITY_EN
    logic mem_par [DEPTH];

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // FSM state and sweep pointer register with synchronous reset into a sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            state_r   <= state_s;
            clr_ptr_r <= clr_ptr_s;
        end
    end

    // Next-state, sweep pointer and memory port control decode.
    always_comb begin
        state_s   = state_r;
        clr_ptr_s = clr_ptr_r;
        wr_en_s   = 1'b0;
        wr_addr_s = addr;
        wr_data_s = data_in;
        rd_en_s   = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                // clr and select are ignored while sweeping.
                wr_en_s   = 1'b1;
                wr_addr_s = clr_ptr_r[ADDR_WIDTH-1:0];
                wr_data_s = {DATA_WIDTH{1'b0}};
                clr_ptr_s = clr_ptr_r + PTR_ONE;
                if (clr_ptr_s == SWEEP_END) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    // clr wins over a simultaneous access, which is dropped.
                    state_s   = ST_CLEAR;
                    clr_ptr_s = {(ADDR_WIDTH + 1){1'b0}};
                end else if (select) begin
                    wr_en_s = op;
                    rd_en_s = ~op;
                end else begin
                    wr_en_s = 1'b0;
                    rd_en_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_ptr_s = {(ADDR_WIDTH + 1){1'b0}};
            end
        endcase
    end

    // Storage array write port; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
`ifdef MEM_PARITY_EN
            mem_par[wr_addr_s] <= even_parity(wr_data_s);
`endif
        end
    end

    // Registered read data, valid pulse and parity check result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= {DATA_WIDTH{1'b0}};
            data_valid <= 1'b0;
            parity_err <= 1'b0;
        end else if (rd_en_s) begin
            data_out   <= mem[addr];
            data_valid <= 1'b1;
`ifdef MEM_PARITY_EN
            parity_err <= (even_parity(mem[addr]) != mem_par[addr]);
`else
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
        end
    end

    // busy is a direct decode of the state register.
    assign busy = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_mem_bank.sv
// Testbench for mem_bank (DATA_WIDTH=8, ADDR_WIDTH=3). Reads push their
// expected {parity_err, data_out} into a queue; a negedge monitor pops and
// compares whenever data_valid is seen.
module tb_mem_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       select;
    logic       op;
    logic [2:0] addr;
    logic [7:0] data_in;
    logic       clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    mem_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .select     (select),
        .op         (op),
        .addr       (addr),
        .data_in    (data_in),
        .clr        (clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got data 0x%0h with no read pending, expected no pulse", data_out);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("read_data", {23'd0, parity_err, data_out}, {23'd0, e});
            end
        end else if (parity_err === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL parity_idle: got parity_err 1 without data_valid, expected 0");
        end
    end

    // Drive one access for one cycle; starts and ends 1 time unit after a rising edge.
    task automatic access(input logic wr, input logic [2:0] a, input logic [7:0] d);
        select  = 1'b1;
        op      = wr;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        select = 1'b0;
        op     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp_d, input logic exp_p);
        exp_q.push_back({exp_p, exp_d});
        access(1'b0, a, 8'h00);
    endtask

    // Count negedges with busy=1, bounded; ends realigned to posedge+1.
    task automatic count_busy(input string name, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        check(name, n, exp_n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        select  = 1'b0;
        op      = 1'b0;
        addr    = 3'd0;
        data_in = 8'h00;
        clr     = 1'b0;

        // Reset for two edges, then the post-reset sweep.
        repeat (2) @(posedge clk);
        #1;
        check("reset_data_out", {24'd0, data_out}, 32'h00);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        count_busy("reset_busy_len", 8);
        check("post_reset_data_out", {24'd0, data_out}, 32'h00);

        // Basic write then read, single valid pulse.
        access(1'b1, 3'd1, 8'h49);
        check("write_no_valid", {31'd0, data_valid}, 32'd0);
        rd(3'd1, 8'h49, 1'b0);
        check("read_valid", {31'd0, data_valid}, 32'd1);
        idle_cycle();
        check("valid_single", {31'd0, data_valid}, 32'd0);

        // A write leaves data_out holding the last read value.
        access(1'b1, 3'd5, 8'h77);
        check("write_hold", {24'd0, data_out}, 32'h49);

        // Corner addresses, back-to-back reads.
        access(1'b1, 3'd0, 8'hCC);
        access(1'b1, 3'd7, 8'h33);
        rd(3'd0, 8'hCC, 1'b0);
        check("b2b_valid0", {31'd0, data_valid}, 32'd1);
        rd(3'd7, 8'h33, 1'b0);
        check("b2b_valid1", {31'd0, data_valid}, 32'd1);
        idle_cycle();
        check("b2b_end", {31'd0, data_valid}, 32'd0);
        rd(3'd5, 8'h77, 1'b0);

        // clr together with a write: the write is dropped, memory cleared.
        access(1'b1, 3'd2, 8'h5A);
        clr     = 1'b1;
        select  = 1'b1;
        op      = 1'b1;
        addr    = 3'd2;
        data_in = 8'hFF;
        @(posedge clk);
        #1;
        clr    = 1'b0;
        select = 1'b0;
        op     = 1'b0;
        count_busy("clr_busy_len", 8);
        rd(3'd1, 8'h00, 1'b0);
        rd(3'd2, 8'h00, 1'b0);

        // Busy lockout: accesses and a second clr during the sweep are ignored.
        access(1'b1, 3'd3, 8'h11);
        clr = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 3'd0, 8'h00);
        clr = 1'b0;
        access(1'b1, 3'd3, 8'hAA);
        count_busy("lockout_busy_rest", 6);
        rd(3'd3, 8'h00, 1'b0);

        // Reset mid-sweep restarts a full sweep.
        access(1'b1, 3'd6, 8'h66);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (3) idle_cycle();
        rst_n = 1'b0;
        idle_cycle();
        check("midsweep_reset_valid", {31'd0, data_valid}, 32'd0);
        rst_n = 1'b1;
        count_busy("midsweep_busy_len", 8);
        rd(3'd6, 8'h00, 1'b0);

`ifdef MEM_PARITY_EN
        // Corrupt a stored parity bit and expect the read to flag it.
        access(1'b1, 3'd4, 8'h01);
        dut.mem_par[4] = ~dut.mem_par[4];
        rd(3'd4, 8'h01, 1'b1);
        rd(3'd0, 8'h00, 1'b0);
`endif

        repeat (3) idle_cycle();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
